fifo_uart_tx: RTL

Downstream consumer of the Synchronous_FIFO. It pops bytes from the FIFO read port and serialises each one as an asynchronous UART frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, then stop bits. The block is the sole reader of its FIFO, so it never issues a read against an empty FIFO. It sits between the FIFO and the chip TX pad.

---
 rtl/fifo_uart_pkg.sv | 28 ++
 rtl/uart_baud_counter.sv | 44 ++++
 rtl/fifo_uart_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and helpers for the FIFO-fed UART transmitter.
//   tx_state_e   : transmitter sequencer states
//   FRAME_CNT_W  : width of the completed-frame counter
//   frame_len()  : clk cycles occupied by one UART frame for a given setup
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } tx_state_e;

   localparam int FRAME_CNT_W = 16;

   // One frame is start + data + optional parity + stop bits, each CLKS_PER_BIT long
   function automatic int frame_len(input int data_width, input int clks_per_bit,
                                    input int parity_en, input int stop_bits);
      return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Free-running bit-period counter, 0..CLKS_PER_BIT-1, held at zero by clr.
//   clk, rst_n : clock and async active-low reset
//   clr        : synchronous clear; the cycle after clr drops is cycle 0 of a bit
//   bit_tick   : high on the last cycle of every bit period
//   pre_tick   : high on the second-to-last cycle, lets the parent register a
//                flag that lands exactly on the last cycle
// -----------------------------------------------------------------------------
module uart_baud_counter
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt_r;

   // Bit-period counter with wrap at the last cycle of each bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1'b1);
      end
   end

   assign bit_tick = (cnt_r == CNT_LAST);
   assign pre_tick = (cnt_r == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from a synchronous FIFO and sends each as an async UART frame:
// start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stops.
//   clk, rst_n    : clock and async active-low reset
//   tx_en         : allows fetching new bytes; a frame in flight always finishes
//   fifo_empty    : FIFO empty flag
//   fifo_rd_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : single-cycle FIFO pop strobe
//   tx            : serial line, idles high
//   busy          : high whenever the sequencer is not idle
//   frame_done    : one-cycle pulse on the last cycle of the last stop bit
//   frame_count   : completed frames, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tx_en,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                   fifo_rd_en,
   output logic                   tx,
   output logic                   busy,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   // Bit index also counts stop bits, so it never needs more than 1 bit extra
   localparam int               IDX_W         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

   tx_state_e             state_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  parity_r;
   logic [IDX_W-1:0]      bit_idx_r;
   logic                  clr_s;
   logic                  bit_tick_s;
   logic                  pre_tick_s;

   function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
      logic even_s;
      even_s = ^data;
      if (PARITY_ODD != 0) begin
         return ~even_s;
      end else begin
         return even_s;
      end
   endfunction

   // Baud counter only runs while a frame is on the line; it restarts at the
   // first start-bit cycle because it is held clear through FETCH and LOAD.
   assign clr_s = (state_r == IDLE) || (state_r == FETCH) || (state_r == LOAD);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr_s),
      .bit_tick (bit_tick_s),
      .pre_tick (pre_tick_s)
   );

   // Frame sequencer: state, shift register, parity and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         shift_r     <= {DATA_WIDTH{1'b0}};
         parity_r    <= 1'b0;
         bit_idx_r   <= {IDX_W{1'b0}};
         tx          <= 1'b1;
         fifo_rd_en  <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= {FRAME_CNT_W{1'b0}};
      end else begin
         fifo_rd_en <= 1'b0;
         frame_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (tx_en && !fifo_empty) begin
                  state_r    <= FETCH;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            FETCH: begin
               state_r <= LOAD;
            end
            LOAD: begin
               shift_r   <= fifo_rd_data;
               parity_r  <= calc_parity(fifo_rd_data);
               bit_idx_r <= {IDX_W{1'b0}};
               tx        <= 1'b0;
               state_r   <= START;
            end
            START: begin
               if (bit_tick_s) begin
                  tx      <= shift_r[0];
                  shift_r <= shift_r >> 1'b1;
                  state_r <= DATA;
               end
            end
            DATA: begin
               if (bit_tick_s) begin
                  shift_r <= shift_r >> 1'b1;
                  if (bit_idx_r == LAST_DATA_IDX) begin
                     bit_idx_r <= {IDX_W{1'b0}};
                     if (PARITY_EN != 0) begin
                        tx      <= parity_r;
                        state_r <= PARITY;
                     end else begin
                        tx      <= 1'b1;
                        state_r <= STOP;
                     end
                  end else begin
                     bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
                     tx        <= shift_r[0];
                  end
               end
            end
            PARITY: begin
               if (bit_tick_s) begin
                  tx      <= 1'b1;
                  state_r <= STOP;
               end
            end
            STOP: begin
               // Raise frame_done one cycle early so it is high on the final stop cycle
               if (pre_tick_s && (bit_idx_r == LAST_STOP_IDX)) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + FRAME_CNT_W'(1'b1);
               end
               if (bit_tick_s) begin
                  if (bit_idx_r == LAST_STOP_IDX) begin
                     bit_idx_r <= {IDX_W{1'b0}};
                     if (tx_en && !fifo_empty) begin
                        state_r    <= FETCH;
                        fifo_rd_en <= 1'b1;
                     end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                     end
                  end else begin
                     bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               tx      <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
